// File: rtl/chunked_add_sequencer.sv
// chunked_add_sequencer: wide add/subtract done one CHUNK-bit slice per cycle on a shared narrow adder

interface full_adder_intf #(parameter int W = 8);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cin;
    logic         cout;
endinterface

module ripple_adder_generic #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;
    // Bit-serial carry ripple across the slice
    always_comb begin
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[W];
    end
endmodule

module chunked_add_sequencer #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             last;

    full_adder_intf #(.W(CHUNK)) fa ();

    ripple_adder_generic #(.W(CHUNK)) u_add (
        .a    (fa.a),
        .b    (fa.b),
        .cin  (fa.cin),
        .sum  (fa.sum),
        .cout (fa.cout)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign busy      = busy_q;

    // Next-state logic: latch operands in IDLE, one slice per RUN cycle, hold in DONE
    always_comb begin
        fa.a    = op_a_q[int'(k_q) * CHUNK +: CHUNK];
        fa.b    = op_b_q[int'(k_q) * CHUNK +: CHUNK];
        fa.cin  = carry_q;
        last    = (k_q == KW'(N - 1));
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        k_d     = k_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                op_a_d  = in_a;
                op_b_d  = in_sub ? ~in_b : in_b;
                carry_d = in_sub ? 1'b1 : in_cin;
                k_d     = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[int'(k_q) * CHUNK +: CHUNK] = fa.sum;
                carry_d = fa.cout;
                k_d     = last ? '0 : k_q + 1'b1;
                if (last) begin
                    cout_d  = fa.cout;
                    ovf_d   = (fa.a[CHUNK-1] == fa.b[CHUNK-1]) && (fa.sum[CHUNK-1] != fa.a[CHUNK-1]);
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_chunked_add_sequencer.sv
// tb_chunked_add_sequencer: directed table, multi-cycle corner cases and random ops on two configurations
module tb_chunked_add_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_sub = 1'b0, in_cin = 1'b0, out_ready = 1'b0;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_ready, out_valid, out_cout, out_ovf, busy;
    logic [31:0] out_sum;

    logic        s_valid = 1'b0, s_sub = 1'b0, s_cin = 1'b0, s_oready = 1'b0;
    logic [7:0]  s_a = '0, s_b = '0;
    logic        s_iready, s_ovalid, s_cout, s_ovf, s_busy;
    logic [7:0]  s_sum;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chunked_add_sequencer #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
    );

    chunked_add_sequencer #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_iready),
        .in_a(s_a), .in_b(s_b), .in_sub(s_sub), .in_cin(s_cin),
        .out_valid(s_ovalid), .out_ready(s_oready), .out_sum(s_sum),
        .out_cout(s_cout), .out_ovf(s_ovf), .busy(s_busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin);
        logic [31:0] bb;
        logic [32:0] r;
        bb = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {32'd0, sub ? 1'b1 : cin};
        return {r[32], (a[31] == bb[31]) && (r[31] != a[31]), r[31:0]};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin);
        logic [7:0] bb;
        logic [8:0] r;
        bb = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {8'd0, sub ? 1'b1 : cin};
        return {r[8], (a[7] == bb[7]) && (r[7] != a[7]), r[7:0]};
    endfunction

    // One request/response on the 32/8 instance; gap idle cycles before, rdly cycles of backpressure after
    task automatic apply(input string name, input vec_t v, input int gap, input int rdly);
        int cyc;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_a = v.a; in_b = v.b; in_sub = v.sub; in_cin = v.cin; in_valid = 1'b1;
        chk({name, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_latency"}, cyc, 4);
        repeat (rdly) @(posedge clk);
        #1;
        chk({name, "_sum"}, out_sum, v.sum);
        chk({name, "_cout"}, out_cout, v.cout);
        chk({name, "_ovf"}, out_ovf, v.ovf);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_drop"}, out_valid, 0);
    endtask

    task automatic apply8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin, input int gap, input int rdly);
        int cyc;
        logic [9:0] e;
        e = model8(a, b, sub, cin);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        s_a = a; s_b = b; s_sub = sub; s_cin = cin; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        cyc = 0;
        while (!s_ovalid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("w8_latency", cyc, 2);
        repeat (rdly) @(posedge clk);
        #1;
        chk("w8_result", {s_cout, s_ovf, s_sum}, e);
        s_oready = 1'b1;
        @(posedge clk); #1;
        s_oready = 1'b0;
    endtask

    initial begin
        vec_t tbl[9];
        vec_t v;
        logic [33:0] e;
        logic [31:0] held;
        logic stable;
        int cyc;
        tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[4] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[5] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        tbl[6] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0};
        tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[8] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};

        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_cout_ovf", {out_cout, out_ovf}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) apply($sformatf("vec%0d", i), tbl[i], 0, 0);

        // Backpressure: new request waits while DONE is held
        @(negedge clk);
        in_a = 32'h0000_0010; in_b = 32'h0000_0020; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 32'hAAAA_0000; in_b = 32'h0000_5555; in_sub = 1'b1; in_cin = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        held = out_sum;
        chk("bp_first_sum", held, 32'h0000_0030);
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!out_valid || out_sum !== held || in_ready || !busy || out_cout || out_ovf) stable = 1'b0;
        end
        chk("bp_hold_stable", stable, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_idle_ready", {in_ready, out_valid, busy}, 3'b100);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accept", {in_ready, busy}, 2'b01);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_second_latency", cyc, 4);
        chk("bp_second", {out_cout, out_ovf, out_sum}, {1'b1, 1'b0, 32'hAAA9_AAAB});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset while the third chunk is pending
        @(negedge clk);
        in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_sub = 1'b0; in_cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_state", {busy, out_valid, in_ready}, 3'b001);
        chk("midrst_sum", out_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("midrst_no_emit", out_valid, 0);
        apply("post_rst", tbl[8], 0, 0);

        for (int i = 0; i < 1000; i++) begin
            v.a = $urandom; v.b = $urandom;
            v.sub = 1'($urandom_range(0, 1)); v.cin = 1'($urandom_range(0, 1));
            if (i % 8 == 0) v.b = v.a;
            e = model32(v.a, v.b, v.sub, v.cin);
            v.sum = e[31:0]; v.ovf = e[32]; v.cout = e[33];
            apply("rand32", v, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        for (int i = 0; i < 300; i++)
            apply8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), $urandom_range(0, 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
